// File: rtl/ram_burst_reader_pkg.sv
// Shared constants and types for the RAM burst reader.
// Tag travels alongside each outstanding RAM read.
package mem_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } burst_state_e;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] a;
  } rd_tag_t;

  function automatic logic [ADDR_W-1:0] addr_inc(
    input logic [ADDR_W-1:0] a
  );
    return a + ADDR_W'(1);
  endfunction
endpackage

// File: rtl/ram_burst_reader_if.sv
// Ready/valid output stream: read word plus its source address.
// master = producer (reader), slave = consumer.
interface ram_burst_reader_if;
  import mem_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );
endinterface

// File: rtl/ram_burst_reader_fifo.sv
// First-word-fall-through FIFO with occupancy count.
// Simultaneous push/pop is legal even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i &&
                   ((count_q < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push)
        wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
      if (do_pop)
        rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign valid_o = (count_q != '0);
  assign dout_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = count_q;

  // Upstream credit accounting must make a dropped push impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push_i && !do_push));
endmodule

// File: rtl/ram_burst_reader.sv
// Walks a RAM address window and streams the returned words
// out through a credit-limited FWFT buffer.
module ram_burst_reader
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = RD_LATENCY + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  ram_burst_reader_if.master out_if
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  burst_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic [ADDR_W-1:0] hold_q;
  logic              done_q, done_d;
  rd_tag_t           pipe_q [RD_LATENCY];

  logic                     issue, pop, credit_ok;
  logic [CW:0]              inflight;
  logic [CW-1:0]            fifo_cnt;
  logic [DATA_W+ADDR_W-1:0] fifo_dout;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + {{CW{1'b0}}, pipe_q[i].v};
  end

  // A pop this cycle frees a slot in time for the new read.
  assign pop = out_if.out_valid && out_if.out_ready;
  assign credit_ok = ({1'b0, fifo_cnt} + inflight
                      - {{CW{1'b0}}, pop}) < DEPTH_C;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    left_d  = left_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            left_d  = count;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (credit_ok && !reset) begin
          issue  = 1'b1;
          addr_d = addr_inc(addr_q);
          left_d = left_q - ADDR_W'(1);
          if (left_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      left_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++)
        pipe_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      hold_q    <= ram_address;
      done_q    <= done_d;
      pipe_q[0] <= '{v: issue, a: addr_q};
      for (int i = 1; i < RD_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (pipe_q[RD_LATENCY-1].v),
    .din_i   ({ram_q, pipe_q[RD_LATENCY-1].a}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .valid_o (out_if.out_valid),
    .count_o (fifo_cnt)
  );

  assign ram_address     = issue ? addr_q : hold_q;
  assign ram_wren        = 1'b0;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign out_if.out_data = fifo_dout[ADDR_W +: DATA_W];
  assign out_if.out_addr = fifo_dout[ADDR_W-1:0];
endmodule
